// File: rtl/uart_rx_frame.sv
// UART receive frame engine: 2-flop synchronizer, start detect, 3-sample majority vote,
// LSB-first deserializer with optional parity and stop check, one-cycle result strobes.
module uart_rx_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int EW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
   localparam logic [EW-1:0] EDGE_S0   = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] EDGE_S2   = EW'(PRESCALE / 2 + 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_meta_q, rx_s_q;
   logic [EW-1:0]           edge_q, edge_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [2:0]              samp_q, samp_d;
   logic                    par_en_q, par_en_d;
   logic                    par_typ_q, par_typ_d;
   logic                    perr_q, perr_d;
   logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
   logic                    dv_q, dv_d;
   logic                    pe_q, pe_d;
   logic                    se_q, se_d;

   logic                    bit_end;
   logic                    samp2_now;
   logic                    vote;

   // The third sample coincides with bit end when PRESCALE is 4, so take it live on that edge.
   assign bit_end   = (edge_q == EDGE_LAST);
   assign samp2_now = (edge_q == EDGE_S2) ? rx_s_q : samp_q[2];
   assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp2_now) | (samp_q[1] & samp2_now);

   always_comb begin
      state_d   = state_q;
      edge_d    = edge_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      samp_d    = samp_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      perr_d    = perr_q;
      pdata_d   = pdata_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;

      if (state_q != S_IDLE) begin
         edge_d = bit_end ? '0 : edge_q + EDGE_ONE;
         for (int i = 0; i < 3; i++) begin
            if (edge_q == EDGE_S0 + EW'(i)) begin
               samp_d[i] = rx_s_q;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d   = S_START;
               edge_d    = EDGE_ONE;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               perr_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = vote ? S_IDLE : S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BIT_ONE;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               perr_d  = (vote != ((^shift_q) ^ par_typ_q));
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (vote && !perr_q) begin
                  pdata_d = shift_q;
                  dv_d    = 1'b1;
               end
               pe_d = perr_q;
               se_d = !vote;
               // A line already low here is the next start bit; re-arm without an idle cycle.
               if (!rx_s_q) begin
                  state_d   = S_START;
                  edge_d    = EDGE_ONE;
                  par_en_d  = PAR_EN;
                  par_typ_d = PAR_TYP;
                  perr_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         edge_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         samp_q    <= '1;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         perr_q    <= 1'b0;
         pdata_q   <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= RX_IN;
         rx_s_q    <= rx_meta_q;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         samp_q    <= samp_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         perr_q    <= perr_d;
         pdata_q   <= pdata_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   assign P_DATA     = pdata_q;
   assign data_valid = dv_q;
   assign par_err    = pe_q;
   assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: table of frames plus hand sequences for glitches,
// back-to-back frames and mid-frame reset; pulses are checked against a scoreboard queue.
module tb_uart_rx_frame;

   localparam int DW = 8;
   localparam int P  = 8;
   localparam int H  = P / 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RX_IN = 1'b1;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          data_valid;
   logic          par_err;
   logic          stp_err;

   always #5 CLK = ~CLK;

   uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       ptyp;
      logic       pbit;
      logic       stopb;
      logic       tog;
      logic       exp_dv;
      logic       exp_pe;
      logic       exp_se;
   } vec_t;

   typedef struct {
      logic       dv;
      logic       pe;
      logic       se;
      logic [7:0] pd;
   } exp_t;

   exp_t       sb[$];
   int         dv_cyc[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         pulses = 0;
   logic [7:0] model_pd = 8'h00;
   logic       prev_any = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      exp_t e;
      if (data_valid | par_err | stp_err) begin
         pulses++;
         total++;
         if (prev_any) begin
            bad++;
            $display("FAIL pulse_width: output high for 2 consecutive cycles at cycle %0d, required 1", cyc);
         end
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b P_DATA=%h, required no pulse",
                     data_valid, par_err, stp_err, P_DATA);
         end else begin
            e = sb.pop_front();
            total++;
            if ({data_valid, par_err, stp_err, P_DATA} !== {e.dv, e.pe, e.se, e.pd}) begin
               bad++;
               $display("FAIL frame_result: got dv=%b pe=%b se=%b P_DATA=%h, required dv=%b pe=%b se=%b P_DATA=%h",
                        data_valid, par_err, stp_err, P_DATA, e.dv, e.pe, e.se, e.pd);
            end else begin
               $display("ok frame_result: cycle=%0d dv=%b pe=%b se=%b P_DATA=%h",
                        cyc, data_valid, par_err, stp_err, P_DATA);
            end
         end
         if (data_valid) dv_cyc.push_back(cyc);
      end
      prev_any = data_valid | par_err | stp_err;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("ok %s: %0h", name, act);
      end
   endtask

   task automatic expect_frame(input logic dv, input logic pe, input logic se, input logic [7:0] d);
      exp_t e;
      if (dv) model_pd = d;
      e.dv = dv;
      e.pe = pe;
      e.se = se;
      e.pd = model_pd;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         RX_IN = 1'b1;
      end
   endtask

   task automatic drive_bit(input logic b, input int glitch_c);
      for (int c = 0; c < P; c++) begin
         @(negedge CLK);
         RX_IN = (c == glitch_c) ? ~b : b;
      end
   endtask

   // Bit index i: 0 = start, 1..DW = data LSB first, then optional parity, then stop.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic stopb, input int glitch_bit, input int abort_bit,
                             input logic tog);
      int nb;
      logic b;
      nb = 2 + DW + (pen ? 1 : 0);
      for (int i = 0; i < nb; i++) begin
         if (i == abort_bit) return;
         if (i == 0) b = 1'b0;
         else if (i <= DW) b = d[i-1];
         else if (pen && i == DW + 1) b = pbit;
         else b = stopb;
         if (tog && i == 4) begin
            PAR_EN  = ~PAR_EN;
            PAR_TYP = ~PAR_TYP;
         end
         drive_bit(b, (i == glitch_bit) ? H : -1);
      end
   endtask

   vec_t vt[12];
   int   p0;
   int   n0;

   initial begin
      vt[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[4]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[5]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[10] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[11] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      check("reset_pdata", 32'(P_DATA), 32'h0);
      check("reset_dv", 32'(data_valid), 32'h0);
      check("reset_pe", 32'(par_err), 32'h0);
      check("reset_se", 32'(stp_err), 32'h0);
      RST = 1'b1;
      idle(10);

      for (int i = 0; i < 12; i++) begin
         PAR_EN  = vt[i].pen;
         PAR_TYP = vt[i].ptyp;
         idle(4);
         expect_frame(vt[i].exp_dv, vt[i].exp_pe, vt[i].exp_se, vt[i].data);
         send_frame(vt[i].data, vt[i].pen, vt[i].pbit, vt[i].stopb, -1, -1, vt[i].tog);
         idle(24);
         check($sformatf("row%0d_pdata", i), 32'(P_DATA), 32'(model_pd));
         check($sformatf("row%0d_drained", i), 32'(sb.size()), 32'h0);
      end

      // Short low glitch on the idle line
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      p0 = pulses;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         RX_IN = 1'b0;
      end
      idle(40);
      check("idle_glitch_pulses", 32'(pulses - p0), 32'h0);

      // One-cycle flip at mid-bit of data bit 5 (value 1), then of data bit 0 (value 0)
      expect_frame(1'b1, 1'b0, 1'b0, 8'hF0);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 6, -1, 1'b0);
      idle(24);
      check("midbit_glitch1_pdata", 32'(P_DATA), 32'hF0);
      expect_frame(1'b1, 1'b0, 1'b0, 8'h0E);
      send_frame(8'h0E, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0);
      idle(24);
      check("midbit_glitch0_pdata", 32'(P_DATA), 32'h0E);

      // Back-to-back frames with no idle gap
      idle(4);
      n0 = dv_cyc.size();
      expect_frame(1'b1, 1'b0, 1'b0, 8'h01);
      expect_frame(1'b1, 1'b0, 1'b0, 8'hFF);
      expect_frame(1'b1, 1'b0, 1'b0, 8'h80);
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      send_frame(8'h80, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      idle(24);
      check("b2b_count", 32'(dv_cyc.size() - n0), 32'd3);
      if (dv_cyc.size() >= n0 + 3) begin
         check("b2b_gap1", 32'(dv_cyc[n0+1] - dv_cyc[n0]), 32'd80);
         check("b2b_gap2", 32'(dv_cyc[n0+2] - dv_cyc[n0+1]), 32'd80);
      end
      check("b2b_pdata", 32'(P_DATA), 32'h80);
      check("b2b_drained", 32'(sb.size()), 32'h0);

      // Reset in the middle of the data bits, then a fresh frame
      idle(4);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 5, 1'b0);
      @(negedge CLK);
      RST   = 1'b0;
      RX_IN = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      model_pd = 8'h00;
      check("midreset_pdata", 32'(P_DATA), 32'h0);
      check("midreset_dv", 32'(data_valid), 32'h0);
      check("midreset_pe", 32'(par_err), 32'h0);
      check("midreset_se", 32'(stp_err), 32'h0);
      p0 = pulses;
      idle(100);
      check("midreset_no_pulse", 32'(pulses - p0), 32'h0);
      expect_frame(1'b1, 1'b0, 1'b0, 8'h5A);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      idle(24);
      check("post_reset_pdata", 32'(P_DATA), 32'h5A);
      check("final_drained", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
